// File: rtl/hub_pkg.sv
// Shared definitions for the hub sink endpoint: request idle encoding,
// drop counter width and the default response entry layout.
package hub_pkg;

    // Value of the request-idle flag when the hub drives its "zero" payload.
    localparam logic HUB_REQ_IDLE = 1'b1;

    // Width of the saturating dropped-request counter.
    localparam int DROP_CNT_W = 8;

    // Default field widths matching the hub's standard configuration.
    localparam int HUB_ADDR_W = 32;
    localparam int HUB_DATA_W = 4;

    // One buffered response: truncated sum plus the originating address.
    typedef struct packed {
        logic [HUB_DATA_W-1:0] sum;
        logic [HUB_ADDR_W-1:0] addr;
    } hub_rsp_entry_t;

    // A request is present whenever the idle flag is not asserted.
    function automatic logic hub_req_valid(input logic c);
        return (c != HUB_REQ_IDLE);
    endfunction

endpackage

// File: rtl/hub_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers. Storage is a plain
// array without reset; the head entry is read straight from the array so
// a word written at edge N is visible at the outputs right after edge N.
module hub_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] count_reg;

    logic          pop_eff;
    logic          push_eff;

    // Pointers are equal when empty; full when only the wrap bits differ.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop of an empty FIFO is ignored; a push into a full FIFO is only
    // legal when the head leaves in the same cycle.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    assign count = count_reg;
    assign rdata = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            unique case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + PW'(1);
                2'b01:   count_reg <= count_reg - PW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/hub_sink_fifo.sv
// Downstream endpoint for one master port of the alternating hub. Each
// non-idle request is turned into {a+b truncated, a}, buffered, and handed
// out on a valid/ready response port. The hub cannot be stalled, so a
// request arriving at a full FIFO that is not being popped is dropped and
// recorded in a sticky flag and a saturating counter.
module hub_sink_fifo
    import hub_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     req_a,
    input  logic [ADDR_WIDTH-1:0]     req_b,
    input  logic                      req_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [ADDR_WIDTH-1:0]     rsp_addr,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_cnt,
    input  logic                      clear_ovf
);

    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] sum_full;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head_entry;

    logic                  push_req;
    logic                  pop;
    logic                  accept;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    logic                  overflow_reg;
    logic                  overflow_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_next;

    // Full-width add; only the low DATA_WIDTH bits are stored, the rest
    // (including the carry) is discarded.
    assign sum_full = req_a + req_b;
    assign wr_entry = {sum_full[DATA_WIDTH-1:0], req_a};

    generate
        if (ADDR_WIDTH > DATA_WIDTH) begin : g_sum_hi
            logic unused_sum_hi;
            assign unused_sum_hi = ^sum_full[ADDR_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    assign push_req = hub_req_valid(req_c);
    assign pop      = rsp_valid && rsp_ready;

    // A full FIFO still takes a request when the head leaves this cycle.
    assign accept = push_req && (!fifo_full || pop);
    assign drop   = push_req && fifo_full && !pop;

    hub_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign count     = fifo_count;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = head_entry[ENTRY_W-1:ADDR_WIDTH];
    assign rsp_addr  = head_entry[ADDR_WIDTH-1:0];

    logic unused_empty;
    assign unused_empty = fifo_empty;

    // Overflow bookkeeping: clear first, then a same-cycle drop lands on
    // top of the cleared value so the drop is never lost.
    always_comb begin
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (clear_ovf) begin
            overflow_next = 1'b0;
            drop_cnt_next = '0;
        end
        if (drop) begin
            overflow_next = 1'b1;
            if (drop_cnt_next != {DROP_CNT_W{1'b1}}) begin
                drop_cnt_next = drop_cnt_next + DROP_CNT_W'(1);
            end
        end
    end

    // Overflow flag and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_hub_sink_fifo.sv
// Scoreboard bench for hub_sink_fifo: stimulus predicts each accepted
// request's response and queues it; a negedge monitor compares every
// handshake plus occupancy and overflow state against the model.
module tb_hub_sink_fifo;

    localparam int AW    = 32;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] req_a = '0;
    logic [AW-1:0] req_b = '0;
    logic          req_c = 1'b1;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clear_ovf = 1'b0;

    hub_sink_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_e;
    exp_t mon_e;
    bit   pend_push  = 0;
    bit   pend_drop  = 0;
    bit   pend_clear = 0;
    int   ovf_m      = 0;
    int   drop_m     = 0;
    int   total      = 0;
    int   bad        = 0;
    int   rsp_seen   = 0;
    int   max_cnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Apply one cycle of inputs and predict what the coming edge does.
    task automatic step(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic c, input logic rdy, input logic clr);
        int sz;
        bit pop_m;
        req_a     = a;
        req_b     = b;
        req_c     = c;
        rsp_ready = rdy;
        clear_ovf = clr;
        sz    = exp_q.size();
        pop_m = (sz != 0) && rdy;
        pend_push  = !c && (sz < DEPTH || pop_m);
        pend_drop  = !c && (sz == DEPTH) && !pop_m;
        pend_clear = clr;
        pend_e.addr = a;
        pend_e.data = DW'((longint'(a) + longint'(b)) % (longint'(1) << DW));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step('0, '0, 1'b1, rdy, 1'b0);
    endtask

    // Monitor: compare DUT state with the model, then retire the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
            check("count", 64'(count), 64'(exp_q.size()));
            check("overflow", 64'(overflow), 64'(ovf_m));
            check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (exp_q.size() != 0 && rsp_ready) begin
                mon_e = exp_q.pop_front();
                rsp_seen++;
                $display("rsp %0d: addr=%0d data=%0d (expected addr=%0d data=%0d)",
                         rsp_seen, rsp_addr, rsp_data, mon_e.addr, mon_e.data);
                check("rsp_addr", 64'(rsp_addr), 64'(mon_e.addr));
                check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
            end
            if (pend_clear) begin
                ovf_m  = 0;
                drop_m = 0;
            end
            if (pend_drop) begin
                ovf_m = 1;
                if (drop_m < 255) drop_m++;
            end
            if (pend_push) exp_q.push_back(pend_e);
            pend_push  = 0;
            pend_drop  = 0;
            pend_clear = 0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b0);

        // 1: mid-cycle reset discards queued entries immediately
        step(1, 1, 1'b0, 1'b0, 1'b0);
        step(2, 3, 1'b0, 1'b0, 1'b0);
        step(4, 4, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd3);
        req_c = 1'b1;
        clear_ovf = 1'b0;
        pend_push = 0; pend_drop = 0; pend_clear = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        ovf_m = 0;
        drop_m = 0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(2, 2, 1'b0, 1'b1, 1'b0);
        check("after_rst_data", 64'(rsp_data), 64'd4);
        idle(1'b1);

        // 2: single request, one-cycle latency
        step(3, 5, 1'b0, 1'b1, 1'b0);
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_data", 64'(rsp_data), 64'd8);
        check("single_addr", 64'(rsp_addr), 64'd3);
        idle(1'b1);
        check("single_drained", 64'(count), 64'd0);

        // 3: truncation and idle payload
        step(32'hF, 32'h3, 1'b0, 1'b1, 1'b0);
        check("trunc_data", 64'(rsp_data), 64'd2);
        step(7, 7, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // 4: overflow with five back-to-back requests, drain, clear
        for (int i = 1; i <= 5; i++) step(AW'(i), 0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drops", 64'(drop_cnt), 64'd1);
        repeat (4) idle(1'b1);
        step(0, 0, 1'b1, 1'b0, 1'b1);
        check("clear_flag", 64'(overflow), 64'd0);
        check("clear_drops", 64'(drop_cnt), 64'd0);

        // 5: full FIFO with simultaneous pop still accepts
        for (int i = 1; i <= 4; i++) step(AW'(20 + i), 0, 1'b0, 1'b0, 1'b0);
        step(9, 0, 1'b0, 1'b1, 1'b0);
        check("fullpop_count", 64'(count), 64'd4);
        check("fullpop_ovf", 64'(overflow), 64'd0);
        repeat (5) idle(1'b1);

        // 6: hub pattern, a request every other cycle
        rsp_seen = 0;
        max_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(AW'(10 + i / 2), 0, 1'b0, 1'b1, 1'b0);
            else            idle(1'b1);
        end
        repeat (2) idle(1'b1);
        check("hub_responses", 64'(rsp_seen), 64'd5);
        check("hub_max_count", 64'(max_cnt), 64'd1);
        check("hub_drops", 64'(drop_cnt), 64'd0);

        // 7: drop counter saturation, then clear racing a drop
        for (int i = 0; i < 264; i++) step(AW'(100 + i), AW'(i), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("sat_drops", 64'(drop_cnt), 64'd255);
        step(1, 1, 1'b0, 1'b0, 1'b1);
        check("clr_drop_flag", 64'(overflow), 64'd1);
        check("clr_drop_cnt", 64'(drop_cnt), 64'd1);
        repeat (5) idle(1'b1);
        step(0, 0, 1'b1, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        repeat (DEPTH + 2) idle(1'b1);
        check("final_empty", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
